// File: rtl/seg7_capture.sv
// Passive decoder for a multiplexed 4-digit active-low 7-segment bus.
// Recovers settled digit glyphs, assembles frames and publishes a stable binary value.
module seg7_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [13:0] value,
    output logic        value_valid,
    output logic        error_shown,
    output logic        glyph_fault
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_TOP = MW'(STABLE_FRAMES);
    localparam logic [3:0] DIG_E = 4'hE;

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_SAMPLED} state_t;

    state_t          r_state;
    logic [3:0]      r_an;
    logic [CW-1:0]   r_cnt;
    logic            r_samp_v;
    logic [6:0]      r_samp_seg;
    logic [1:0]      r_samp_idx;

    logic [3:0]      w_low;
    logic            w_an_valid;
    logic [1:0]      w_an_idx;

    assign w_low      = ~an;
    assign w_an_valid = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

    always_comb begin
        w_an_idx = 2'd0;
        case (w_low)
            4'b0010: w_an_idx = 2'd1;
            4'b0100: w_an_idx = 2'd2;
            4'b1000: w_an_idx = 2'd3;
            default: w_an_idx = 2'd0;
        endcase
    end

    // Stage 0: wait for a stable single-anode selection, then grab seg once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_WAIT;
            r_an       <= 4'hF;
            r_cnt      <= '0;
            r_samp_v   <= 1'b0;
            r_samp_seg <= 7'h7F;
            r_samp_idx <= 2'd0;
        end else begin
            r_samp_v <= 1'b0;
            if (r_state != S_WAIT && an == r_an) begin
                if (r_state == S_SETTLE) begin
                    if (r_cnt == CNT_LAST) begin
                        r_samp_v   <= 1'b1;
                        r_samp_seg <= seg;
                        r_state    <= S_SAMPLED;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end else if (w_an_valid) begin
                r_state    <= S_SETTLE;
                r_an       <= an;
                r_cnt      <= '0;
                r_samp_idx <= w_an_idx;
            end else begin
                r_state <= S_WAIT;
                r_an    <= 4'hF;
                r_cnt   <= '0;
            end
        end
    end

    // Glyph decode on the lit set {a..g}.
    logic [6:0] w_lit;
    logic [3:0] w_dig;
    logic       w_bad;

    assign w_lit = ~r_samp_seg;

    always_comb begin
        w_dig = 4'd0;
        w_bad = 1'b0;
        case (w_lit)
            7'b0000000: w_dig = 4'd0;
            7'b1111110: w_dig = 4'd0;
            7'b0110000: w_dig = 4'd1;
            7'b1101101: w_dig = 4'd2;
            7'b1111001: w_dig = 4'd3;
            7'b0110011: w_dig = 4'd4;
            7'b1011011: w_dig = 4'd5;
            7'b1011111: w_dig = 4'd6;
            7'b1110000: w_dig = 4'd7;
            7'b1111111: w_dig = 4'd8;
            7'b1111011: w_dig = 4'd9;
            7'b1001111: w_dig = DIG_E;
            default:    w_bad = 1'b1;
        endcase
    end

    // Stage 1: frame assembly; an "E" is stored as digit code 14.
    logic [3:0]  r_dig [4];
    logic [3:0]  r_mask;
    logic        r_frame_v;
    logic        r_frame_err;
    logic [13:0] r_frame_val;

    logic [3:0]  w_d [4];
    logic [3:0]  w_mask_next;
    logic        w_err;
    logic [13:0] w_t0, w_t1, w_t2, w_t3, w_sum;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dig
        assign w_d[gi] = (r_samp_idx == 2'(gi)) ? w_dig : r_dig[gi];
    end

    assign w_mask_next = r_mask | (4'd1 << r_samp_idx);
    assign w_err = (w_d[0] == DIG_E) || (w_d[1] == DIG_E) ||
                   (w_d[2] == DIG_E) || (w_d[3] == DIG_E);
    assign w_t0  = {10'd0, w_d[0]};
    assign w_t1  = {10'd0, w_d[1]};
    assign w_t2  = {10'd0, w_d[2]};
    assign w_t3  = {10'd0, w_d[3]};
    assign w_sum = (w_t3 << 10) - (w_t3 << 4) - (w_t3 << 3)
                 + (w_t2 << 6) + (w_t2 << 5) + (w_t2 << 2)
                 + (w_t1 << 3) + (w_t1 << 1) + w_t0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_dig[i] <= 4'd0;
            r_mask      <= 4'd0;
            r_frame_v   <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_val <= 14'd0;
            glyph_fault <= 1'b0;
        end else begin
            r_frame_v   <= 1'b0;
            glyph_fault <= 1'b0;
            if (r_samp_v) begin
                if (w_bad) begin
                    glyph_fault <= 1'b1;
                    r_mask      <= 4'd0;
                end else begin
                    r_dig[r_samp_idx] <= w_dig;
                    if (w_mask_next == 4'hF) begin
                        r_mask      <= 4'd0;
                        r_frame_v   <= 1'b1;
                        r_frame_err <= w_err;
                        r_frame_val <= w_err ? 14'd0 : w_sum;
                    end else begin
                        r_mask <= w_mask_next;
                    end
                end
            end
        end
    end

    // Stage 2: stability filter and publish.
    logic            r_prev_v;
    logic            r_prev_err;
    logic [13:0]     r_prev_val;
    logic [MW-1:0]   r_match;
    logic            r_published;

    logic            w_same;
    logic            w_differs;
    logic [MW-1:0]   w_match_next;

    assign w_same    = r_prev_v && (r_prev_err == r_frame_err) && (r_prev_val == r_frame_val);
    assign w_differs = !r_published || (r_frame_err != error_shown) ||
                       (!r_frame_err && (r_frame_val != value));
    assign w_match_next = !w_same ? MW'(1) :
                          (r_match == MATCH_TOP) ? r_match : r_match + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_v    <= 1'b0;
            r_prev_err  <= 1'b0;
            r_prev_val  <= 14'd0;
            r_match     <= '0;
            r_published <= 1'b0;
            value       <= 14'd0;
            value_valid <= 1'b0;
            error_shown <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (r_frame_v) begin
                r_prev_v   <= 1'b1;
                r_prev_err <= r_frame_err;
                r_prev_val <= r_frame_val;
                r_match    <= w_match_next;
                if (w_match_next == MATCH_TOP && w_differs) begin
                    value_valid <= 1'b1;
                    error_shown <= r_frame_err;
                    r_published <= 1'b1;
                    if (!r_frame_err) value <= r_frame_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a frame-level reference model checked every cycle,
// plus literal end-of-scenario expectations.
module tb_seg7_capture;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [13:0] value;
    logic        value_valid, error_shown, glyph_fault;

    seg7_capture #(.SETTLE_CYCLES(SETTLE), .STABLE_FRAMES(STABLE)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .value(value), .value_valid(value_valid),
        .error_shown(error_shown), .glyph_fault(glyph_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_vv     = 0;
    int n_gf     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Glyphs as lists of lit segments; index 10 = blank, 11 = E.
    string glyph_tab [12] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                              "acdefg", "abc", "abcdefg", "abcdfg", "", "adefg"};

    function automatic logic [6:0] lit_of(input string s);
        logic [6:0] m = 7'd0;
        for (int i = 0; i < s.len(); i++) m[6 - (int'(s[i]) - 97)] = 1'b1;
        return m;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        return ~lit_of(glyph_tab[d]);
    endfunction

    function automatic int sel_pos(input logic [3:0] a);
        int zeros = 0;
        int p = -1;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; p = i; end
        return (zeros == 1) ? p : -1;
    endfunction

    // ---------------- reference model ----------------
    bit          model_on = 0;
    int          run, last_pos;
    int          m_dig [4];
    bit          m_e [4];
    bit [3:0]    m_mask;
    bit          m_prev_v, m_prev_err, m_pub;
    int          m_prev_val, m_cnt;
    bit          f_st, pa_v, pa_err, pb_v, pb_err;
    int          pa_val, pb_val;
    bit          exp_vv, exp_err, exp_gf;
    int          exp_val;

    task automatic model_clear();
        run = 0; last_pos = -1; m_mask = 0;
        for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_e[i] = 0; end
        m_prev_v = 0; m_prev_err = 0; m_prev_val = 0; m_cnt = 0; m_pub = 0;
        f_st = 0; pa_v = 0; pb_v = 0; pa_err = 0; pb_err = 0; pa_val = 0; pb_val = 0;
        exp_vv = 0; exp_err = 0; exp_gf = 0; exp_val = 0;
    endtask

    task automatic model_sample(input int pos, input logic [6:0] s);
        int d = -1;
        bit is_e = 0;
        bit ferr;
        int fval;
        for (int k = 0; k < 10; k++) if (s == glyph(k)) d = k;
        if (s == glyph(10)) d = 0;
        if (s == glyph(11)) begin d = 0; is_e = 1; end
        if (d < 0) begin
            f_st = 1;
            m_mask = 0;
            return;
        end
        m_dig[pos] = d;
        m_e[pos] = is_e;
        m_mask[pos] = 1'b1;
        if (m_mask != 4'hF) return;
        m_mask = 0;
        ferr = m_e[0] | m_e[1] | m_e[2] | m_e[3];
        fval = ferr ? 0 : m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        if (m_prev_v && m_prev_err == ferr && m_prev_val == fval)
            m_cnt = (m_cnt >= STABLE) ? STABLE : m_cnt + 1;
        else
            m_cnt = 1;
        m_prev_v = 1; m_prev_err = ferr; m_prev_val = fval;
        if (m_cnt == STABLE && (!m_pub || ferr != exp_err || (!ferr && fval != exp_val))) begin
            m_pub = 1;
            pa_v = 1; pa_err = ferr; pa_val = fval;
        end
    endtask

    always @(posedge clk) begin
        int pos;
        if (reset) begin
            model_clear();
            model_on = 1;
        end else if (model_on) begin
            exp_gf = f_st; f_st = 0;
            exp_vv = pb_v;
            if (pb_v) begin
                exp_err = pb_err;
                if (!pb_err) exp_val = pb_val;
            end
            pb_v = pa_v; pb_err = pa_err; pb_val = pa_val; pa_v = 0;
            pos = sel_pos(an);
            if (pos < 0) run = 0;
            else if (pos == last_pos && run > 0) run++;
            else run = 1;
            last_pos = pos;
            if (run == SETTLE + 1) model_sample(pos, seg);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_on) begin
            check("value",       int'(value),       exp_val);
            check("value_valid", int'(value_valid), int'(exp_vv));
            check("error_shown", int'(error_shown), int'(exp_err));
            check("glyph_fault", int'(glyph_fault), int'(exp_gf));
            if (value_valid) n_vv++;
            if (glyph_fault) n_gf++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic show(input int pos, input logic [6:0] s, input int hold);
        @(negedge clk);
        an  = ~(4'b0001 << pos);
        seg = s;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        an = 4'hF; seg = 7'h7F;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input int g3, input int g2, input int g1, input int g0, input int hold);
        show(0, glyph(g0), hold);
        show(1, glyph(g1), hold);
        show(2, glyph(g2), hold);
        show(3, glyph(g3), hold);
    endtask

    initial begin
        reset = 1'b1; an = 4'hF; seg = 7'h7F;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_value", int'(value), 0);
        check("reset_err",   int'(error_shown), 0);
        idle(4);

        // "0347" with leading blank, three frames
        n_vv = 0;
        repeat (3) scan(10, 3, 4, 7, 16);
        idle(6);
        check("t1_pulses", n_vv, 1);
        check("t1_value",  int'(value), 347);
        check("t1_err",    int'(error_shown), 0);

        // "E" on thousands, blanks elsewhere
        n_vv = 0;
        repeat (2) scan(11, 10, 10, 10, 16);
        idle(6);
        check("t2_pulses", n_vv, 1);
        check("t2_err",    int'(error_shown), 1);
        check("t2_value",  int'(value), 347);

        // holds too short to settle
        n_vv = 0;
        repeat (2) scan(1, 2, 3, 4, SETTLE - 1);
        idle(6);
        check("t3_pulses", n_vv, 0);
        check("t3_value",  int'(value), 347);
        check("t3_err",    int'(error_shown), 1);

        // unrecognised glyph then clean "9999"
        n_vv = 0; n_gf = 0;
        show(0, 7'b0101010, 16);
        idle(2);
        repeat (2) scan(9, 9, 9, 9, 16);
        idle(6);
        check("t4_faults", n_gf, 1);
        check("t4_pulses", n_vv, 1);
        check("t4_value",  int'(value), 9999);
        check("t4_err",    int'(error_shown), 0);

        // alternating frames never stabilise
        n_vv = 0;
        repeat (2) begin
            scan(0, 1, 2, 0, 16);
            scan(0, 1, 2, 1, 16);
        end
        idle(6);
        check("t5_pulses", n_vv, 0);
        check("t5_value",  int'(value), 9999);

        // reset mid-frame, then "0005"
        show(0, glyph(5), 16);
        show(1, glyph(10), 16);
        show(2, glyph(10), 16);
        @(negedge clk);
        reset = 1'b1; an = 4'hF; seg = 7'h7F;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_value", int'(value), 0);
        check("t6_rst_err",   int'(error_shown), 0);
        check("t6_rst_gf",    int'(glyph_fault), 0);
        n_vv = 0;
        scan(10, 10, 10, 5, 16);
        idle(6);
        check("t6_one_frame", n_vv, 0);
        scan(10, 10, 10, 5, 16);
        idle(6);
        check("t6_pulses", n_vv, 1);
        check("t6_value",  int'(value), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end
endmodule
